// File: rtl/mem_access_unit.sv
// Memory-access stage: byte-lane load/store over a req/gnt/rvalid bus,
// ALU bypass, fault flags. Optional watchdog enabled by MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int BYTE           = 8,
  parameter int HALFWORD       = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              dm_read_enable,
  input  logic              dm_write_enable,
  input  logic [XLEN-1:0]   alu_data_out,
  input  logic [XLEN-1:0]   dm_write_data,
  input  logic [2:0]        dm_access_type,
  output logic              out_valid,
  output logic [XLEN-1:0]   dm_read_data,
  output logic [XLEN-1:0]   dm_data_bypass,
  output logic              misaligned_fault,
  output logic              illegal_op,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state, next;

  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [OW-1:0]   r_off;
  logic [2:0]      r_type;
  logic            r_we;

  logic accept, is_mem, type_ok, misal;
  logic start_mem, done_byp, done_ill, done_mis;
  logic done_st, done_ld, timeout;

  logic [XLEN-1:0] shifted, ld_val;
  logic [NB-1:0]   be_b, be_h;

  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);

  // Classify the incoming request in IDLE.
  always_comb begin
    accept  = in_valid && (state == IDLE);
    is_mem  = dm_read_enable ^ dm_write_enable;
    type_ok = (dm_access_type == T_B)  ||
              (dm_access_type == T_H)  ||
              (dm_access_type == T_W)  ||
              (dm_access_type == T_BU) ||
              (dm_access_type == T_HU);
    misal   = 1'b0;
    if ((dm_access_type == T_H) || (dm_access_type == T_HU))
      misal = alu_data_out[0];
    else if (dm_access_type == T_W)
      misal = (alu_data_out[1:0] != 2'b00);
    done_byp  = accept && !dm_read_enable
                       && !dm_write_enable;
    done_ill  = accept && ((dm_read_enable && dm_write_enable)
                       || (is_mem && !type_ok));
    done_mis  = accept && is_mem && type_ok && misal;
    start_mem = accept && is_mem && type_ok && !misal;
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] cnt;

  // Watchdog: counts cycles in REQ/WAIT_R, restarts on each state entry.
  always_ff @(posedge clk) begin
    if (rst || (next != state))
      cnt <= '0;
    else if (state != IDLE)
      cnt <= cnt + 32'd1;
  end

  assign timeout = (state != IDLE) &&
                   (cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic; a grant or rvalid wins over the watchdog.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start_mem) next = REQ;
      REQ:     if (mem_gnt) next = r_we ? IDLE : WAIT_R;
               else if (timeout) next = IDLE;
      WAIT_R:  if (mem_rvalid || timeout) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Bus outputs and completion events decoded from the state.
  always_comb begin
    be_b = {{(NB-1){1'b0}}, 1'b1} << r_off;
    be_h = {{(NB-2){1'b0}}, 2'b11} << r_off;
    in_ready  = (state == IDLE);
    mem_req   = (state == REQ);
    mem_we    = mem_req && r_we;
    mem_addr  = mem_req ? r_addr : '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (!r_we || (r_type == T_W)) begin
        mem_be = '1;
      end else if ((r_type == T_H) || (r_type == T_HU)) begin
        mem_be = be_h;
      end else begin
        mem_be = be_b;
      end
      if (r_we) begin
        if (r_type == T_W)
          mem_wdata = r_wdata;
        else if ((r_type == T_H) || (r_type == T_HU))
          mem_wdata = {(XLEN/HALFWORD){r_wdata[HALFWORD-1:0]}};
        else
          mem_wdata = {(XLEN/BYTE){r_wdata[BYTE-1:0]}};
      end
    end
    done_st = (state == REQ) && mem_gnt && r_we;
    done_ld = (state == WAIT_R) && mem_rvalid;
  end

  // Align the returned word to the addressed lane and extend.
  always_comb begin
    shifted = mem_rdata >> (r_off * BYTE);
    unique case (r_type)
      T_B:     ld_val = {{(XLEN-BYTE){shifted[BYTE-1]}},
                         shifted[BYTE-1:0]};
      T_H:     ld_val = {{(XLEN-HALFWORD){shifted[HALFWORD-1]}},
                         shifted[HALFWORD-1:0]};
      T_BU:    ld_val = {{(XLEN-BYTE){1'b0}},
                         shifted[BYTE-1:0]};
      T_HU:    ld_val = {{(XLEN-HALFWORD){1'b0}},
                         shifted[HALFWORD-1:0]};
      default: ld_val = shifted;
    endcase
  end

  // Latch the request at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_off   <= '0;
      r_type  <= '0;
      r_we    <= 1'b0;
    end else if (start_mem) begin
      r_addr  <= {alu_data_out[XLEN-1:OW], {OW{1'b0}}};
      r_wdata <= dm_write_data;
      r_off   <= alu_data_out[OW-1:0];
      r_type  <= dm_access_type;
      r_we    <= dm_write_enable;
    end
  end

  // Register completion results; unrelated result is zeroed on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      misaligned_fault <= 1'b0;
      illegal_op       <= 1'b0;
      dm_read_data     <= '0;
      dm_data_bypass   <= '0;
    end else begin
      out_valid        <= done_byp || done_ill || done_mis ||
                          done_st || done_ld || timeout;
      misaligned_fault <= done_mis;
      illegal_op       <= done_ill;
      if (done_byp || done_ill || done_mis ||
          done_st || done_ld || timeout) begin
        dm_read_data   <= done_ld ? ld_val : '0;
        dm_data_bypass <= done_byp ? alu_data_out : '0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Bus error flag accompanies a watchdog completion.
  always_ff @(posedge clk) begin
    if (rst) bus_error <= 1'b0;
    else     bus_error <= timeout && !done_st && !done_ld;
  end
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Watchdog steps run only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        dm_read_enable;
  logic        dm_write_enable;
  logic [31:0] alu_data_out;
  logic [31:0] dm_write_data;
  logic [2:0]  dm_access_type;
  logic        out_valid;
  logic [31:0] dm_read_data;
  logic [31:0] dm_data_bypass;
  logic        misaligned_fault;
  logic        illegal_op;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .XLEN(32), .BYTE(8), .HALFWORD(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dm_read_enable(dm_read_enable),
    .dm_write_enable(dm_write_enable),
    .alu_data_out(alu_data_out),
    .dm_write_data(dm_write_data),
    .dm_access_type(dm_access_type),
    .out_valid(out_valid),
    .dm_read_data(dm_read_data),
    .dm_data_bypass(dm_data_bypass),
    .misaligned_fault(misaligned_fault),
    .illegal_op(illegal_op),
    .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd,
                       input logic wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    in_valid        = v;
    dm_read_enable  = rd;
    dm_write_enable = wr;
    dm_access_type  = t;
    alu_data_out    = a;
    dm_write_data   = d;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    drive(0, 0, 0, 3'b000, 0, 0);
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rdata", dm_read_data, 0);
    chk("rst_bypass", dm_data_bypass, 0);
    rst = 1'b0;

    // Back-to-back bypass.
    drive(1, 0, 0, 3'b010, 32'h1234_5678, 0);
    @(negedge clk);
    chk("byp1_valid", out_valid, 1);
    chk("byp1_data", dm_data_bypass, 32'h1234_5678);
    chk("byp1_req", mem_req, 0);
    drive(1, 0, 0, 3'b010, 32'hCAFE_0001, 0);
    @(negedge clk);
    chk("byp2_valid", out_valid, 1);
    chk("byp2_data", dm_data_bypass, 32'hCAFE_0001);
    drive(0, 0, 0, 3'b000, 0, 0);
    @(negedge clk);
    chk("byp_idle_valid", out_valid, 0);
    chk("byp_hold", dm_data_bypass, 32'hCAFE_0001);

    // LB at 0x103, grant after 2 cycles, rvalid 3 cycles later.
    drive(1, 1, 0, 3'b000, 32'h103, 0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    chk("lb_req", mem_req, 1);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_be", mem_be, 4'b1111);
    chk("lb_we", mem_we, 0);
    chk("lb_ready", in_ready, 0);
    @(negedge clk);
    chk("lb_req_hold", mem_req, 1);
    chk("lb_addr_hold", mem_addr, 32'h100);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("lb_wait_req", mem_req, 0);
    chk("lb_wait_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    chk("lb_wait_valid", out_valid, 0);
    mem_rvalid = 1; mem_rdata = 32'h80FF_0000;
    @(negedge clk);
    mem_rvalid = 0;
    chk("lb_valid", out_valid, 1);
    chk("lb_data", dm_read_data, 32'hFFFF_FF80);
    chk("lb_byp_zero", dm_data_bypass, 0);
    @(negedge clk);
    chk("lb_pulse", out_valid, 0);
    chk("lb_hold", dm_read_data, 32'hFFFF_FF80);
    chk("lb_ready_back", in_ready, 1);

    // SH at 0x202.
    drive(1, 0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_we", mem_we, 1);
    chk("sh_valid_early", out_valid, 0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("sh_valid", out_valid, 1);
    chk("sh_req_drop", mem_req, 0);
    chk("sh_rdata_zero", dm_read_data, 0);

    // SB at 0x101.
    drive(1, 0, 1, 3'b000, 32'h101, 32'h1234_565A);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    chk("sb_be", mem_be, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("sb_valid", out_valid, 1);

    // Misaligned LW and LHU.
    drive(1, 1, 0, 3'b010, 32'h301, 0);
    @(negedge clk);
    chk("lw_mis_valid", out_valid, 1);
    chk("lw_mis_flag", misaligned_fault, 1);
    chk("lw_mis_req", mem_req, 0);
    drive(1, 1, 0, 3'b101, 32'h305, 0);
    @(negedge clk);
    chk("lhu_mis_valid", out_valid, 1);
    chk("lhu_mis_flag", misaligned_fault, 1);
    chk("lhu_mis_req", mem_req, 0);

    // Aligned LHU at 0x306.
    drive(1, 1, 0, 3'b101, 32'h306, 0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    chk("lhu_addr", mem_addr, 32'h304);
    chk("lhu_mis_clr", misaligned_fault, 0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h8001_0000;
    @(negedge clk);
    mem_rvalid = 0;
    chk("lhu_valid", out_valid, 1);
    chk("lhu_data", dm_read_data, 32'h0000_8001);

    // Same word via LH sign-extends.
    drive(1, 1, 0, 3'b001, 32'h306, 0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
    chk("lh_data", dm_read_data, 32'hFFFF_8001);

    // Illegal: both enables, then undefined funct3.
    drive(1, 1, 1, 3'b010, 32'h400, 0);
    @(negedge clk);
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal_op, 1);
    chk("ill_req", mem_req, 0);
    drive(1, 1, 0, 3'b011, 32'h400, 0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    chk("undef_flag", illegal_op, 1);
    chk("undef_req", mem_req, 0);
    @(negedge clk);
    chk("ill_pulse", illegal_op, 0);

    // Reset while waiting for read data.
    drive(1, 1, 0, 3'b010, 32'h400, 0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("abort_in_wait", in_ready, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", in_ready, 1);
    chk("abort_req", mem_req, 0);
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 0;
    chk("abort_no_valid", out_valid, 0);
    chk("abort_rdata", dm_read_data, 0);

    // Grant never comes.
    drive(1, 1, 0, 3'b010, 32'h500, 0);
    @(negedge clk);
    drive(0, 0, 0, 3'b000, 0, 0);
`ifdef MEM_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (!seen) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
    end
    chk("to_seen", seen, 1);
    chk("to_bus_error", bus_error, 1);
    chk("to_ready", in_ready, 1);
    chk("to_req", mem_req, 0);
    @(negedge clk);
    chk("to_pulse", out_valid, 0);
`else
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("nto_no_valid", seen, 0);
    chk("nto_req", mem_req, 1);
    chk("nto_bus_error", bus_error, 0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 0;
    chk("nto_data", dm_read_data, 32'hDEAD_BEEF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
